vc_ingress_router: RTL and testbench

//  Ingress end of the VC datapath: pops 6-bit words from the Main FIFO (first-word-fall-through), classifies each by
//  its VC select bit and pushes it into the VC0 or VC1 FIFO. The VC0/VC1 FIFOs are later drained by the egress

---
 rtl/vc_ingress_pkg.sv | 22 ++
 rtl/vc_occupancy_cnt.sv | 31 +++
 rtl/vc_ingress_router.sv | 129 ++++++++++++
 tb/tb_vc_ingress_router.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vc_ingress_pkg.sv
// Shared definitions for the VC ingress router: default sizes, FSM state
// encoding and the threshold clamp used when thresholds are latched.
package vc_ingress_pkg;

  localparam int DATA_W_DEF     = 6;
  localparam int VC_SEL_BIT_DEF = 4;
  localparam int VC_DEPTH_DEF   = 8;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  // A zero threshold would pause forever and anything above the depth could
  // let a FIFO overflow; both fall back to the full depth.
  function automatic int clamp_thr(input logic [3:0] u, input int depth);
    if (u == 4'd0 || int'(u) > depth) return depth;
    return int'(u);
  endfunction

endpackage

// File: rtl/vc_occupancy_cnt.sv
// Occupancy tracker for one VC FIFO. Counts registered writes against reads
// from the egress side and raises pause once the occupancy, including a write
// still in flight, reaches the latched threshold.
module vc_occupancy_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic [CNT_W-1:0] thr,
  output logic [CNT_W-1:0] count,
  output logic             pause,
  output logic             underflow
);

  // A read at zero is an egress-side fault: the count holds at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign pause     = (count + CNT_W'(inc)) >= thr;
  assign underflow = dec && (count == '0);

endmodule

// File: rtl/vc_ingress_router.sv
// Ingress router: pops first-word-fall-through words from the Main FIFO and
// writes each, one cycle later, into the VC0 or VC1 FIFO chosen by its select
// bit. Strictly in order: a paused head stalls the whole stream.
// Optional build macro VC_STATS_EN adds saturating per-VC push counters
// (vc0_words, vc1_words).
module vc_ingress_router
  import vc_ingress_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int VC_SEL_BIT = VC_SEL_BIT_DEF,
  parameter int VC_DEPTH   = VC_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [3:0]        Umbral_VC0,
  input  logic [3:0]        Umbral_VC1,
  input  logic [DATA_W-1:0] main_data,
  input  logic              main_empty,
  output logic              main_pop,
  input  logic              vc0_pop,
  input  logic              vc1_pop,
  output logic              vc0_push,
  output logic              vc1_push,
  output logic [DATA_W-1:0] vc0_data,
  output logic [DATA_W-1:0] vc1_data,
  output logic              vc0_pause,
  output logic              vc1_pause,
  output logic              idle_out,
`ifdef VC_STATS_EN
  output logic [7:0]        vc0_words,
  output logic [7:0]        vc1_words,
`endif
  output logic              error_out
);

  localparam int CNT_W = $clog2(VC_DEPTH) + 1;

  state_t                        state;
  logic [1:0][CNT_W-1:0]         thr;
  logic [1:0][CNT_W-1:0]         cnt;
  logic [1:0]                    pause;
  logic [1:0]                    unf;
  logic [1:0]                    pop_in;
  logic [1:0]                    push_q;
  logic [1:0][DATA_W-1:0]        data_q;
  logic [1:0]                    sel;
  logic                          head_vc;

  assign head_vc  = main_data[VC_SEL_BIT];
  assign main_pop = (state != ST_INIT) && !main_empty && !pause[head_vc];
  assign sel      = main_pop ? (head_vc ? 2'b10 : 2'b01) : 2'b00;
  assign pop_in   = {vc1_pop, vc0_pop};

  // Control FSM; thresholds track the config inputs for as long as we sit in INIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
      thr   <= {2{CNT_W'(VC_DEPTH)}};
    end else begin
      case (state)
        ST_INIT: begin
          thr[0] <= CNT_W'(clamp_thr(Umbral_VC0, VC_DEPTH));
          thr[1] <= CNT_W'(clamp_thr(Umbral_VC1, VC_DEPTH));
          if (!init) state <= ST_IDLE;
        end
        ST_IDLE:   if (init) state <= ST_INIT; else if (!main_empty) state <= ST_ACTIVE;
        ST_ACTIVE: if (init) state <= ST_INIT; else if (main_empty) state <= ST_IDLE;
        default:   state <= ST_INIT;
      endcase
    end
  end

  // Write strobes and data to the VC FIFOs; data holds between pushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      push_q <= '0;
      data_q <= '0;
    end else begin
      push_q <= sel;
      for (int v = 0; v < 2; v++) if (sel[v]) data_q[v] <= main_data;
    end
  end

  for (genvar v = 0; v < 2; v++) begin : g_vc
    vc_occupancy_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (push_q[v]),
      .dec       (pop_in[v]),
      .thr       (thr[v]),
      .count     (cnt[v]),
      .pause     (pause[v]),
      .underflow (unf[v])
    );
  end

  // Sticky underflow flag; init does not clear it.
  always_ff @(posedge clk) begin
    if (reset)     error_out <= 1'b0;
    else if (|unf) error_out <= 1'b1;
  end

  assign vc0_push  = push_q[0];
  assign vc1_push  = push_q[1];
  assign vc0_data  = data_q[0];
  assign vc1_data  = data_q[1];
  assign vc0_pause = pause[0];
  assign vc1_pause = pause[1];
  assign idle_out  = (state == ST_IDLE) && (cnt[0] == '0) && (cnt[1] == '0);

`ifdef VC_STATS_EN
  logic [1:0][7:0] words;

  // Saturating count of pushes per VC, surviving init.
  always_ff @(posedge clk) begin
    if (reset) begin
      words <= '0;
    end else begin
      for (int v = 0; v < 2; v++)
        if (push_q[v] && words[v] != 8'hFF) words[v] <= words[v] + 8'd1;
    end
  end

  assign vc0_words = words[0];
  assign vc1_words = words[1];
`endif

endmodule

// File: tb/tb_vc_ingress_router.sv
// Bench for vc_ingress_router: a hand-computed vector table for the threshold,
// classification and error sequence, short directed sequences, then random
// traffic checked cycle by cycle against a behavioural occupancy model.
module tb_vc_ingress_router;

  logic       clk = 1'b0;
  logic       reset = 1'b1, init = 1'b0;
  logic [3:0] u0 = 4'd8, u1 = 4'd8;
  logic [5:0] mdata = 6'd0;
  logic       mempty = 1'b1, p0 = 1'b0, p1 = 1'b0;
  logic       main_pop, vc0_push, vc1_push, vc0_pause, vc1_pause, idle_out, error_out;
  logic [5:0] vc0_data, vc1_data;
`ifdef VC_STATS_EN
  logic [7:0] vc0_words, vc1_words;
`endif

  vc_ingress_router dut (
    .clk(clk), .reset(reset), .init(init), .Umbral_VC0(u0), .Umbral_VC1(u1),
    .main_data(mdata), .main_empty(mempty), .main_pop(main_pop),
    .vc0_pop(p0), .vc1_pop(p1), .vc0_push(vc0_push), .vc1_push(vc1_push),
    .vc0_data(vc0_data), .vc1_data(vc1_data), .vc0_pause(vc0_pause),
    .vc1_pause(vc1_pause), .idle_out(idle_out),
`ifdef VC_STATS_EN
    .vc0_words(vc0_words), .vc1_words(vc1_words),
`endif
    .error_out(error_out)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Model state: mode 0=config, 1=idle, 2=streaming; occupancy per VC;
  // word written last cycle (pending write) and last data written per VC.
  int m_mode, m_err;
  int m_occ[2], m_thr[2], m_pend[2], m_last[2], m_words[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int clampm(input int u);
    return (u == 0 || u > 8) ? 8 : u;
  endfunction

  function automatic int paused(input int v);
    return (m_occ[v] + m_pend[v] >= m_thr[v]) ? 1 : 0;
  endfunction

  function automatic int exp_pop();
    int hv = int'(mdata[4]);
    return (m_mode != 0 && !mempty && paused(hv) == 0) ? 1 : 0;
  endfunction

  task automatic model_check();
    chk("main_pop", 32'(main_pop), 32'(exp_pop()));
    chk("vc0_push", 32'(vc0_push), 32'(m_pend[0]));
    chk("vc1_push", 32'(vc1_push), 32'(m_pend[1]));
    chk("vc0_data", 32'(vc0_data), 32'(m_last[0]));
    chk("vc1_data", 32'(vc1_data), 32'(m_last[1]));
    chk("vc0_pause", 32'(vc0_pause), 32'(paused(0)));
    chk("vc1_pause", 32'(vc1_pause), 32'(paused(1)));
    chk("idle_out", 32'(idle_out), 32'((m_mode == 1 && m_occ[0] == 0 && m_occ[1] == 0) ? 1 : 0));
    chk("error_out", 32'(error_out), 32'(m_err));
`ifdef VC_STATS_EN
    chk("vc0_words", 32'(vc0_words), 32'(m_words[0]));
    chk("vc1_words", 32'(vc1_words), 32'(m_words[1]));
`endif
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    int pop, hv;
    int rd[2];
    if (reset) begin
      m_mode = 0; m_err = 0;
      for (int v = 0; v < 2; v++) begin
        m_occ[v] = 0; m_thr[v] = 8; m_pend[v] = 0; m_last[v] = 0; m_words[v] = 0;
      end
      return;
    end
    pop = exp_pop();
    hv  = int'(mdata[4]);
    rd[0] = int'(p0); rd[1] = int'(p1);
    for (int v = 0; v < 2; v++) begin
      if (rd[v] == 1 && m_occ[v] == 0) m_err = 1;
      m_occ[v] = m_occ[v] + m_pend[v] - rd[v];
      if (m_occ[v] < 0) m_occ[v] = 0;
      if (m_pend[v] == 1 && m_words[v] < 255) m_words[v]++;
      m_pend[v] = (pop == 1 && hv == v) ? 1 : 0;
      if (m_pend[v] == 1) m_last[v] = int'(mdata);
    end
    if (m_mode == 0) begin
      m_thr[0] = clampm(int'(u0));
      m_thr[1] = clampm(int'(u1));
      if (!init) m_mode = 1;
    end else if (init) m_mode = 0;
    else m_mode = mempty ? 1 : 2;
  endtask

  task automatic drive(input bit r, input bit in, input int a, input int b,
                       input bit e, input int d, input bit q0, input bit q1);
    reset = r; init = in; u0 = 4'(a); u1 = 4'(b);
    mempty = e; mdata = 6'(d); p0 = q0; p1 = q1;
  endtask

  // One model-checked clock: check just after the falling edge, then clock.
  task automatic step();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  typedef struct {
    bit       in;
    bit [3:0] th0;
    bit       e;
    bit [5:0] d;
    bit       q0, q1;
    bit       x_pop, x_push0;
    bit [5:0] x_d0;
    bit       x_push1;
    bit [5:0] x_d1;
    bit       x_pz0, x_pz1, x_idle, x_err;
  } vec_t;

  vec_t tv[19];

  initial begin
    tv[0]  = '{1, 3, 0, 6'h05, 0, 0, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0, 0};
    tv[1]  = '{0, 3, 0, 6'h05, 0, 0, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0, 0};
    tv[2]  = '{0, 3, 0, 6'h05, 0, 0, 1, 0, 6'h00, 0, 6'h00, 0, 0, 1, 0};
    tv[3]  = '{0, 3, 0, 6'h05, 0, 0, 1, 1, 6'h05, 0, 6'h00, 0, 0, 0, 0};
    tv[4]  = '{0, 3, 0, 6'h05, 0, 0, 1, 1, 6'h05, 0, 6'h00, 0, 0, 0, 0};
    tv[5]  = '{0, 3, 0, 6'h05, 0, 0, 0, 1, 6'h05, 0, 6'h00, 1, 0, 0, 0};
    tv[6]  = '{0, 3, 0, 6'h05, 0, 0, 0, 0, 6'h05, 0, 6'h00, 1, 0, 0, 0};
    tv[7]  = '{0, 3, 0, 6'h05, 1, 0, 0, 0, 6'h05, 0, 6'h00, 1, 0, 0, 0};
    tv[8]  = '{0, 3, 0, 6'h05, 0, 0, 1, 0, 6'h05, 0, 6'h00, 0, 0, 0, 0};
    tv[9]  = '{0, 3, 0, 6'h15, 0, 0, 1, 1, 6'h05, 0, 6'h00, 1, 0, 0, 0};
    tv[10] = '{0, 3, 1, 6'h15, 0, 0, 0, 0, 6'h05, 1, 6'h15, 1, 0, 0, 0};
    tv[11] = '{0, 3, 1, 6'h15, 1, 1, 0, 0, 6'h05, 0, 6'h15, 1, 0, 0, 0};
    tv[12] = '{0, 3, 1, 6'h15, 1, 0, 0, 0, 6'h05, 0, 6'h15, 0, 0, 0, 0};
    tv[13] = '{0, 3, 1, 6'h15, 1, 0, 0, 0, 6'h05, 0, 6'h15, 0, 0, 0, 0};
    tv[14] = '{0, 3, 1, 6'h15, 0, 0, 0, 0, 6'h05, 0, 6'h15, 0, 0, 1, 0};
    tv[15] = '{0, 3, 1, 6'h15, 1, 0, 0, 0, 6'h05, 0, 6'h15, 0, 0, 1, 0};
    tv[16] = '{0, 3, 1, 6'h15, 0, 0, 0, 0, 6'h05, 0, 6'h15, 0, 0, 1, 1};
    tv[17] = '{1, 3, 1, 6'h15, 0, 0, 0, 0, 6'h05, 0, 6'h15, 0, 0, 1, 1};
    tv[18] = '{1, 3, 1, 6'h15, 0, 0, 0, 0, 6'h05, 0, 6'h15, 0, 0, 0, 1};

    // Reset for two clocks, with init high and a non-empty Main FIFO.
    drive(1, 1, 8, 8, 0, 6'h05, 0, 0);
    @(posedge clk); model_update(); @(negedge clk);
    #1;
    chk("rst main_pop", 32'(main_pop), 0);
    chk("rst vc0_push", 32'(vc0_push), 0);
    chk("rst vc1_push", 32'(vc1_push), 0);
    chk("rst vc0_data", 32'(vc0_data), 0);
    chk("rst vc1_data", 32'(vc1_data), 0);
    chk("rst pause", 32'({vc0_pause, vc1_pause}), 0);
    chk("rst idle", 32'(idle_out), 0);
    chk("rst error", 32'(error_out), 0);
    step();

    // Vector table: threshold 3 on VC0, stall, classification, error.
    for (int i = 0; i < 19; i++) begin
      drive(0, tv[i].in, int'(tv[i].th0), 8, tv[i].e, int'(tv[i].d), tv[i].q0, tv[i].q1);
      #1;
      chk($sformatf("tv%0d main_pop", i), 32'(main_pop), 32'(tv[i].x_pop));
      chk($sformatf("tv%0d vc0_push", i), 32'(vc0_push), 32'(tv[i].x_push0));
      chk($sformatf("tv%0d vc0_data", i), 32'(vc0_data), 32'(tv[i].x_d0));
      chk($sformatf("tv%0d vc1_push", i), 32'(vc1_push), 32'(tv[i].x_push1));
      chk($sformatf("tv%0d vc1_data", i), 32'(vc1_data), 32'(tv[i].x_d1));
      chk($sformatf("tv%0d vc0_pause", i), 32'(vc0_pause), 32'(tv[i].x_pz0));
      chk($sformatf("tv%0d vc1_pause", i), 32'(vc1_pause), 32'(tv[i].x_pz1));
      chk($sformatf("tv%0d idle", i), 32'(idle_out), 32'(tv[i].x_idle));
      chk($sformatf("tv%0d error", i), 32'(error_out), 32'(tv[i].x_err));
      @(posedge clk); model_update(); @(negedge clk);
    end

    // Simultaneous push and pop on VC1 at count 2 (threshold 4).
    drive(1, 1, 8, 4, 1, 0, 0, 0); step();
    drive(0, 1, 8, 4, 1, 0, 0, 0); step();
    drive(0, 0, 8, 4, 1, 0, 0, 0); step();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 8, 4, 0, 6'h10 + i, 0, 0); step(); end
    drive(0, 0, 8, 4, 1, 0, 0, 1); step();
    drive(0, 0, 8, 4, 1, 0, 0, 1); step();
    drive(0, 0, 8, 4, 1, 0, 0, 0); step();

    // Reset on the edge right after a pop: no push follows.
    drive(0, 0, 8, 8, 0, 6'h05, 0, 0); step();
    drive(1, 0, 8, 8, 0, 6'h05, 0, 0); step();
    drive(0, 0, 8, 8, 0, 6'h05, 0, 0);
    #1;
    chk("post-rst vc0_push", 32'(vc0_push), 0);
    chk("post-rst main_pop", 32'(main_pop), 0);
`ifdef VC_STATS_EN
    chk("post-rst vc0_words", 32'(vc0_words), 0);
`endif
    step();

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      drive(($urandom_range(0, 399) == 0), ($urandom_range(0, 59) == 0),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 3), int'($urandom_range(0, 63)),
            ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
